// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// receive FSM encodings and the smallest bit divisor the sampler supports.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Three taps around mid-bit need at least this many clocks per bit.
    localparam int MIN_BIT_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_e;

    // Reserved mode 2'b11 behaves as no parity.
    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead word FIFO for received UART words.
// Ports: clk, reset (async high), clr_i (sync flush), push_i/wdata_i,
// pop_i/rdata_o, full_o, empty_o, count_o (occupancy).
module uart_rx_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              do_push;
    logic              do_pop;
    logic [AW:0]       used;

    // Pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot a same-cycle push needs.
    assign do_push = push_i && (!full_o || do_pop);

    assign used    = wptr_q - rptr_q;
    assign count_o = CNT_W'(used);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-tap majority sampling,
// runtime parity / stop-bit mode, tagged words, valid/ready output.
// Ports: clk, reset (async high), bit_div, parity_mode, stop2, rx,
// clr_buffer, rx_data/rx_valid/rx_ready, parity_err, frame_err,
// overrun (sticky), rx_busy, fifo_count.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH word buffer;
// otherwise a single holding register is used.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 20,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     bit_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    input  logic                 rx,
    input  logic                 clr_buffer,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy,
    output logic [CNT_W-1:0]     fifo_count
);

    localparam int BIT_W  = 4;
    localparam int WORD_W = DATA_BITS + 2;

    // Synchroniser and edge detect.
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;
    logic fall;

    rx_state_e state_q, state_d;

    logic [DIV_W-1:0]     cnt_q;
    logic [DIV_W-1:0]     div_q;
    logic [1:0]           par_q;
    logic                 stop2_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 v0_q;
    logic                 v1_q;
    logic                 perr_q;
    logic                 ferr_q;

    logic [DIV_W-1:0]  half;
    logic              at_v0;
    logic              at_v1;
    logic              at_mid;
    logic              at_end;
    logic              maj;
    logic              last_bit;
    logic              exp_par;
    logic              commit;
    logic [WORD_W-1:0] word;

    logic              overrun_q;
    logic [WORD_W-1:0] head;
    logic              head_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall = rx_prev_q && !rx_s_q;

    // Taps at half-1 and half are stored; the vote resolves on the
    // third tap, which is the "mid" event used by the FSM.
    assign half     = div_q >> 1;
    assign at_v0    = (cnt_q == half - 1'b1);
    assign at_v1    = (cnt_q == half);
    assign at_mid   = (cnt_q == half + 1'b1);
    assign at_end   = (cnt_q == div_q - 1'b1);
    assign maj      = (v0_q & v1_q) | (v0_q & rx_s_q) | (v1_q & rx_s_q);
    assign last_bit = (bit_q == BIT_W'(DATA_BITS - 1));
    assign exp_par  = (par_q == PAR_ODD) ? ~(^shift_q) : ^shift_q;

    // FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        if (clr_buffer) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fall) state_d = ST_START;
                end
                ST_START: begin
                    if (at_mid && maj)
                        state_d = ST_IDLE;
                    else if (at_end)
                        state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (at_end && last_bit)
                        state_d = parity_on(par_q) ? ST_PARITY : ST_STOP1;
                end
                ST_PARITY: begin
                    if (at_end) state_d = ST_STOP1;
                end
                // The last stop bit ends at its mid-point so the next
                // start edge is seen even with a slightly fast sender.
                ST_STOP1: begin
                    if (at_mid && !stop2_q)
                        state_d = ST_IDLE;
                    else if (at_end)
                        state_d = ST_STOP2;
                end
                ST_STOP2: begin
                    if (at_mid) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs.
    always_comb begin
        rx_busy = (state_q != ST_IDLE);
        commit  = 1'b0;
        if (!clr_buffer && at_mid) begin
            commit = ((state_q == ST_STOP1) && !stop2_q) ||
                     (state_q == ST_STOP2);
        end
        word = {ferr_q | ~maj, perr_q, shift_q};
    end

    // Bit timing and frame datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            div_q   <= '0;
            par_q   <= PAR_NONE;
            stop2_q <= 1'b0;
            bit_q   <= '0;
            shift_q <= '0;
            v0_q    <= 1'b1;
            v1_q    <= 1'b1;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else if (clr_buffer) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            cnt_q <= '0;
            if (fall) begin
                div_q   <= bit_div;
                par_q   <= parity_mode;
                stop2_q <= stop2;
                bit_q   <= '0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
            end
        end else begin
            cnt_q <= at_end ? '0 : cnt_q + 1'b1;
            if (at_v0) v0_q <= rx_s_q;
            if (at_v1) v1_q <= rx_s_q;
            if (at_mid) begin
                unique case (state_q)
                    ST_DATA:
                        shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                    ST_PARITY:
                        perr_q <= (maj != exp_par);
                    ST_STOP1, ST_STOP2:
                        if (!maj) ferr_q <= 1'b1;
                    default: ;
                endcase
            end
            if (at_end && state_q == ST_DATA) bit_q <= bit_q + 1'b1;
        end
    end

`ifdef UART_RX_FIFO_EN

    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;

    assign fifo_pop = !fifo_empty && rx_ready;
    assign head_vld = !fifo_empty;

    uart_rx_fifo #(
        .DATA_W (WORD_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr_buffer),
        .push_i  (commit),
        .wdata_i (word),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (clr_buffer) begin
            overrun_q <= 1'b0;
        end else if (commit && fifo_full && !fifo_pop) begin
            overrun_q <= 1'b1;
        end
    end

`else

    logic [WORD_W-1:0] hold_q;
    logic              hold_vld_q;
    logic              hold_pop;

    assign hold_pop   = hold_vld_q && rx_ready;
    assign head       = hold_q;
    assign head_vld   = hold_vld_q;
    assign fifo_count = {{(CNT_W-1){1'b0}}, hold_vld_q};

    // A held word is kept; the newer word is the one dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (clr_buffer) begin
            hold_vld_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (commit) begin
            if (!hold_vld_q || hold_pop) begin
                hold_q     <= word;
                hold_vld_q <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (hold_pop) begin
            hold_vld_q <= 1'b0;
        end
    end

`endif

    // Outputs read as zero while nothing is held.
    assign rx_valid   = head_vld;
    assign rx_data    = head_vld ? head[DATA_BITS-1:0] : '0;
    assign parity_err = head_vld && head[DATA_BITS];
    assign frame_err  = head_vld && head[DATA_BITS+1];
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: frames are driven bit by bit and the
// expected {frame_err, parity_err, data} is queued; a monitor pops on handshake.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int DB    = 8;
    localparam int DIV_W = 20;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int DIV   = 16;
`ifdef UART_RX_FIFO_EN
    localparam int KEEP  = DEPTH;
`else
    localparam int KEEP  = 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] bit_div;
    logic [1:0]       parity_mode;
    logic             stop2;
    logic             rx;
    logic             clr_buffer;
    logic [DB-1:0]    rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             parity_err;
    logic             frame_err;
    logic             overrun;
    logic             rx_busy;
    logic [CNT_W-1:0] fifo_count;

    int passed = 0;
    int total  = 0;
    int vcyc   = 0;
    logic [DB+1:0] sb [$];

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_BITS  (DB),
        .DIV_W      (DIV_W),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_div     (bit_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .rx          (rx),
        .clr_buffer  (clr_buffer),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .rx_busy     (rx_busy),
        .fifo_count  (fifo_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        logic [DB+1:0] e;
        if (!reset && rx_valid) vcyc++;
        if (!reset && rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_word: got %0h, expected none",
                         {frame_err, parity_err, rx_data});
            end else begin
                e = sb.pop_front();
                chk("word", {22'd0, frame_err, parity_err, rx_data}, {22'd0, e});
            end
        end
    end

    task automatic bit_out(input logic v);
        rx = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic has_par,
                              input logic pbit, input logic s1,
                              input logic has_s2, input logic s2,
                              input logic push, input logic ef,
                              input logic ep);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (push) sb.push_back({ef, ep, d});
        bit_out(1'b0);
        for (int i = 0; i < DB; i++) bit_out(d[i]);
        if (has_par) bit_out(pbit);
        bit_out(s1);
        if (has_s2) bit_out(s2);
        rx = 1'b1;
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: got %0d words left, expected 0",
                     sb.size());
            sb.delete();
        end
    endtask

    task automatic pulse_clr();
        clr_buffer = 1'b1;
        @(posedge clk);
        #1;
        clr_buffer = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        bit_div     = DIV_W'(DIV);
        parity_mode = 2'b00;
        stop2       = 1'b0;
        rx          = 1'b1;
        clr_buffer  = 1'b0;
        rx_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);

        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_count", fifo_count, 0);

        // 8N1 0xA5
        vcyc = 0;
        send_frame(8'hA5, 0, 0, 1, 0, 0, 1, 0, 0);
        wait_sb(200);
        repeat (5) @(posedge clk);
        #1;
        chk("valid_pulse", vcyc, 1);
        chk("valid_low", rx_valid, 0);

        // 8E1 / 8O1 with parity bit 1 on 0x03
        parity_mode = 2'b01;
        send_frame(8'h03, 1, 1, 1, 0, 0, 1, 0, 1);
        wait_sb(200);
        parity_mode = 2'b10;
        send_frame(8'h03, 1, 1, 1, 0, 0, 1, 0, 0);
        wait_sb(200);
        parity_mode = 2'b11;
        send_frame(8'hC3, 0, 0, 1, 0, 0, 1, 0, 0);
        wait_sb(200);

        // 8N2 with second stop low, then a clean 8N2
        parity_mode = 2'b00;
        stop2 = 1'b1;
        send_frame(8'h5A, 0, 0, 1, 1, 0, 1, 1, 0);
        wait_sb(200);
        send_frame(8'h3C, 0, 0, 1, 1, 1, 1, 0, 0);
        wait_sb(200);
        stop2 = 1'b0;
        send_frame(8'h81, 0, 0, 0, 0, 0, 1, 1, 0);
        wait_sb(200);

        // glitch
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("glitch_busy_hi", rx_busy, 1);
        repeat (30) @(posedge clk);
        #1;
        chk("glitch_busy_lo", rx_busy, 0);
        chk("glitch_valid", rx_valid, 0);

        // overrun
        rx_ready = 1'b0;
        for (int k = 0; k <= KEEP; k++)
            send_frame(DB'(k), 0, 0, 1, 0, 0, k < KEEP, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovr_count", fifo_count, KEEP);
        chk("ovr_flag", overrun, 1);
        chk("ovr_head", rx_data, 0);
        rx_ready = 1'b1;
        wait_sb(200);
        chk("ovr_sticky", overrun, 1);
        chk("ovr_drained", fifo_count, 0);
        pulse_clr();
        chk("clr_overrun", overrun, 0);

        // flush of a held word
        rx_ready = 1'b0;
        send_frame(8'h77, 0, 0, 1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("held_count", fifo_count, 1);
        pulse_clr();
        chk("clr_count", fifo_count, 0);
        chk("clr_valid", rx_valid, 0);
        rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // reset mid-DATA of 0xFF
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b1);
        bit_out(1'b1);
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2 * DIV) @(posedge clk);
        #1;
        chk("rst_mid_busy", rx_busy, 0);
        chk("rst_mid_count", fifo_count, 0);
        send_frame(8'h11, 0, 0, 1, 0, 0, 1, 0, 0);
        wait_sb(200);
        repeat (DIV) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
